// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the load/store stage of the data processor.
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        LS_IDLE     = 2'd0,
        LS_REQUEST  = 2'd1,
        LS_WAIT_ACK = 2'd2
    } loadstore_state_t;

    localparam logic [3:0] LS_SEL_BYTE = 4'b0001;
    localparam logic [3:0] LS_SEL_HALF = 4'b0011;
    localparam logic [3:0] LS_SEL_WORD = 4'b1111;

    // An access is misaligned when its lanes would spill past byte lane 3.
    function automatic logic ls_is_misaligned(input logic [3:0] size, input logic [1:0] ofs);
        return ((size == LS_SEL_HALF) && (ofs == 2'd3)) ||
               ((size == LS_SEL_WORD) && (ofs != 2'd0));
    endfunction

endpackage

// File: rtl/loadstore_align.sv
// Combinational lane logic: store data replication / select shift and
// load data extraction with sign or zero extension.
module loadstore_align
    import ecap5_dproc_pkg::*;
(
    input  logic [31:0] st_data,
    input  logic [3:0]  st_size,
    input  logic [1:0]  st_ofs,
    output logic [31:0] st_dat,
    output logic [3:0]  st_sel,
    input  logic [31:0] ld_raw,
    input  logic [3:0]  ld_size,
    input  logic [1:0]  ld_ofs,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_sel = st_size << st_ofs;
        case (st_size)
            LS_SEL_BYTE: st_dat = {4{st_data[7:0]}};
            LS_SEL_HALF: st_dat = {2{st_data[15:0]}};
            default:     st_dat = st_data;
        endcase
    end

    always_comb begin
        ld_shifted = ld_raw >> {ld_ofs, 3'b000};
        case (ld_size)
            LS_SEL_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
            LS_SEL_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
            default:     ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/loadstore.sv
// Memory stage: one pipelined Wishbone B4 transaction per load/store, pass-through otherwise.
// Optional alignment check enabled by defining LOADSTORE_ALIGN_CHECK_EN (adds misaligned_o).
module loadstore
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic [1:0]  debug_state_o
`ifdef LOADSTORE_ALIGN_CHECK_EN
    ,
    output logic        misaligned_o
`endif
);

    // Handshake: an instruction transfers on a cycle where input_valid_i and
    // input_ready_o are both high; ready is only offered in IDLE when write-back
    // can accept, so output_valid_o is a single-cycle pulse never needing a hold.
    loadstore_state_t state;

    logic [3:0]  size_q;
    logic [1:0]  ofs_q;
    logic        unsigned_q;
    logic        write_q;
    logic        reg_write_q;
    logic [4:0]  reg_addr_q;

    logic        accept;
    logic        misaligned_req;
    logic        complete;
    logic [31:0] st_dat;
    logic [3:0]  st_sel;
    logic [31:0] ld_data;

    assign input_ready_o = rst_ni & (state == LS_IDLE) & output_ready_i;
    assign accept        = input_valid_i & input_ready_o;
    assign debug_state_o = state;

`ifdef LOADSTORE_ALIGN_CHECK_EN
    assign misaligned_req = ls_enable_i & ls_is_misaligned(ls_sel_i, result_i[1:0]);
`else
    assign misaligned_req = 1'b0;
`endif

    // Ack while still stalled does not complete; stb must first be taken.
    assign complete = ((state == LS_REQUEST) & ~wb_stall_i & wb_ack_i) |
                      ((state == LS_WAIT_ACK) & wb_ack_i);

    loadstore_align u_align (
        .st_data     (ls_write_data_i),
        .st_size     (ls_sel_i),
        .st_ofs      (result_i[1:0]),
        .st_dat      (st_dat),
        .st_sel      (st_sel),
        .ld_raw      (wb_dat_i),
        .ld_size     (size_q),
        .ld_ofs      (ofs_q),
        .ld_unsigned (unsigned_q),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= LS_IDLE;
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
            reg_addr_o     <= '0;
            reg_data_o     <= '0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            wb_sel_o       <= '0;
            wb_we_o        <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_cyc_o       <= 1'b0;
            size_q         <= '0;
            ofs_q          <= '0;
            unsigned_q     <= 1'b0;
            write_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            reg_addr_q     <= '0;
`ifdef LOADSTORE_ALIGN_CHECK_EN
            misaligned_o   <= 1'b0;
`endif
        end else begin
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
`ifdef LOADSTORE_ALIGN_CHECK_EN
            misaligned_o   <= 1'b0;
`endif
            case (state)
                LS_IDLE: begin
                    if (accept && !ls_enable_i) begin
                        output_valid_o <= 1'b1;
                        reg_write_o    <= reg_write_i;
                        reg_addr_o     <= reg_addr_i;
                        reg_data_o     <= result_i;
                    end else if (accept && misaligned_req) begin
                        output_valid_o <= 1'b1;
                        reg_addr_o     <= reg_addr_i;
`ifdef LOADSTORE_ALIGN_CHECK_EN
                        misaligned_o   <= 1'b1;
`endif
                    end else if (accept) begin
                        wb_adr_o    <= {result_i[31:2], 2'b00};
                        wb_dat_o    <= st_dat;
                        wb_sel_o    <= st_sel;
                        wb_we_o     <= ls_write_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        size_q      <= ls_sel_i;
                        ofs_q       <= result_i[1:0];
                        unsigned_q  <= ls_unsigned_load_i;
                        write_q     <= ls_write_i;
                        reg_write_q <= reg_write_i;
                        reg_addr_q  <= reg_addr_i;
                        state       <= LS_REQUEST;
                    end
                end
                LS_REQUEST: begin
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        if (!wb_ack_i) begin
                            state <= LS_WAIT_ACK;
                        end
                    end
                end
                LS_WAIT_ACK: ;
                default: state <= LS_IDLE;
            endcase

            if (complete) begin
                wb_cyc_o       <= 1'b0;
                wb_we_o        <= 1'b0;
                output_valid_o <= 1'b1;
                reg_write_o    <= reg_write_q & ~write_q;
                reg_addr_o     <= reg_addr_q;
                reg_data_o     <= ld_data;
                state          <= LS_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_loadstore.sv
// Self-checking bench for loadstore: directed scenarios plus randomized
// loads/stores/pass-throughs checked against an arithmetic reference model.
module tb_loadstore;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        input_ready_o;
    logic        input_valid_i;
    logic [31:0] result_i;
    logic        ls_enable_i;
    logic        ls_write_i;
    logic [31:0] ls_write_data_i;
    logic [3:0]  ls_sel_i;
    logic        ls_unsigned_load_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic        output_ready_i;
    logic        output_valid_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic [1:0]  debug_state_o;
`ifdef LOADSTORE_ALIGN_CHECK_EN
    logic        misaligned_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          stb_cycles;
        bit          unstable;
        bit          ready_seen;
        bit          got_valid;
        int          latency;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] data;
        logic        cyc_at_done;
        logic        valid_after;
    } mem_obs_t;

    loadstore dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .input_ready_o      (input_ready_o),
        .input_valid_i      (input_valid_i),
        .result_i           (result_i),
        .ls_enable_i        (ls_enable_i),
        .ls_write_i         (ls_write_i),
        .ls_write_data_i    (ls_write_data_i),
        .ls_sel_i           (ls_sel_i),
        .ls_unsigned_load_i (ls_unsigned_load_i),
        .reg_write_i        (reg_write_i),
        .reg_addr_i         (reg_addr_i),
        .output_ready_i     (output_ready_i),
        .output_valid_o     (output_valid_o),
        .reg_write_o        (reg_write_o),
        .reg_addr_o         (reg_addr_o),
        .reg_data_o         (reg_data_o),
        .wb_adr_o           (wb_adr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_sel_o           (wb_sel_o),
        .wb_we_o            (wb_we_o),
        .wb_stb_o           (wb_stb_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_dat_i           (wb_dat_i),
        .wb_ack_i           (wb_ack_i),
        .wb_stall_i         (wb_stall_i),
        .debug_state_o      (debug_state_o)
`ifdef LOADSTORE_ALIGN_CHECK_EN
        ,
        .misaligned_o       (misaligned_o)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(logic [31:0] dat, int ofs, int size, bit uns);
        longint span = longint'(1) << (8 * size);
        longint v = (longint'(dat) >> (8 * ofs)) % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_sel(int ofs, int size);
        int m = ((1 << size) - 1) << ofs;
        return 4'(m & 15);
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] d, int size);
        if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] size_code(int size);
        return 4'((1 << size) - 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        input_valid_i      = 1'b0;
        result_i           = '0;
        ls_enable_i        = 1'b0;
        ls_write_i         = 1'b0;
        ls_write_data_i    = '0;
        ls_sel_i           = 4'b0000;
        ls_unsigned_load_i = 1'b0;
        reg_write_i        = 1'b0;
        reg_addr_i         = '0;
        output_ready_i     = 1'b1;
        wb_dat_i           = '0;
        wb_ack_i           = 1'b0;
        wb_stall_i         = 1'b0;
    endtask

    // Presents one instruction and returns just after the accepting edge.
    task automatic drive_accept(input logic [31:0] res, input logic en, input logic wr,
                                input logic [31:0] data, input logic [3:0] sel, input logic uns,
                                input logic rw, input logic [4:0] ra);
        @(negedge clk_i);
        input_valid_i      = 1'b1;
        result_i           = res;
        ls_enable_i        = en;
        ls_write_i         = wr;
        ls_write_data_i    = data;
        ls_sel_i           = sel;
        ls_unsigned_load_i = uns;
        reg_write_i        = rw;
        reg_addr_i         = ra;
        @(posedge clk_i);
        #1;
        input_valid_i = 1'b0;
        ls_enable_i   = 1'b0;
    endtask

    // Acts as the Wishbone slave for one transaction: stall_n cycles of stall,
    // then ack wait_n cycles after stb is taken (0 = ack together with take).
    task automatic serve_mem(input int stall_n, input int wait_n, input logic [31:0] ack_dat,
                             output mem_obs_t o);
        int  c = 0;
        bit  first = 1;
        o.stb_cycles = 0;
        o.unstable   = 0;
        o.ready_seen = 0;
        o.got_valid  = 0;
        o.latency    = -1;
        o.adr = '0; o.dat = '0; o.sel = '0; o.we = 1'b0;
        o.rw = 1'b0; o.ra = '0; o.data = '0; o.cyc_at_done = 1'b0;
        for (int k = 0; k < 40 && !o.got_valid; k++) begin
            @(negedge clk_i);
            if (output_valid_o) begin
                o.got_valid   = 1;
                o.latency     = k;
                o.rw          = reg_write_o;
                o.ra          = reg_addr_o;
                o.data        = reg_data_o;
                o.cyc_at_done = wb_cyc_o;
                wb_ack_i      = 1'b0;
                wb_stall_i    = 1'b0;
            end else begin
                if (wb_stb_o) begin
                    o.stb_cycles++;
                    if (first) begin
                        o.adr = wb_adr_o; o.dat = wb_dat_o; o.sel = wb_sel_o; o.we = wb_we_o;
                        first = 0;
                    end else if (wb_adr_o !== o.adr || wb_dat_o !== o.dat ||
                                 wb_sel_o !== o.sel || wb_we_o !== o.we) begin
                        o.unstable = 1;
                    end
                end
                if (wb_cyc_o) begin
                    if (input_ready_o) o.ready_seen = 1;
                    wb_stall_i = (c < stall_n);
                    wb_ack_i   = (c == stall_n + wait_n);
                    wb_dat_i   = ack_dat;
                    c++;
                end else begin
                    wb_stall_i = 1'b0;
                    wb_ack_i   = 1'b0;
                end
            end
        end
        @(negedge clk_i);
        o.valid_after = output_valid_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        input_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total_cnt++;
        if ({input_ready_o, output_valid_o, reg_write_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {input_ready_o, output_valid_o, reg_write_o, wb_cyc_o, wb_stb_o, wb_we_o});
        end else pass_cnt++;
        total_cnt++;
        if ({wb_adr_o, wb_dat_o, reg_data_o} !== 96'b0 || wb_sel_o !== 4'b0 || reg_addr_o !== 5'b0) begin
            $display("FAIL reset_data: adr %h dat %h reg_data %h sel %b expected zeros",
                     wb_adr_o, wb_dat_o, reg_data_o, wb_sel_o);
        end else pass_cnt++;
        input_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        total_cnt++;
        if (input_ready_o !== 1'b1 || debug_state_o !== 2'd0) begin
            $display("FAIL reset_release: ready %b state %0d expected 1 / 0", input_ready_o, debug_state_o);
        end else pass_cnt++;
        output_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (input_ready_o !== 1'b0) begin
            $display("FAIL ready_follows_output_ready: got %b expected 0", input_ready_o);
        end else pass_cnt++;
        output_ready_i = 1'b1;
    endtask

    task automatic test_passthrough();
        drive_accept(32'h1234, 1'b0, 1'b0, 32'h0, 4'b0, 1'b0, 1'b1, 5'd5);
        @(negedge clk_i);
        total_cnt++;
        if (output_valid_o !== 1'b1 || reg_data_o !== 32'h1234 || reg_addr_o !== 5'd5 ||
            reg_write_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            $display("FAIL passthrough: valid %b data %h addr %0d rw %b cyc %b expected 1 00001234 5 1 0",
                     output_valid_o, reg_data_o, reg_addr_o, reg_write_o, wb_cyc_o);
        end else pass_cnt++;
        @(negedge clk_i);
        total_cnt++;
        if (output_valid_o !== 1'b0 || reg_write_o !== 1'b0) begin
            $display("FAIL passthrough_pulse: valid %b rw %b expected 0 0", output_valid_o, reg_write_o);
        end else pass_cnt++;
    endtask

    task automatic test_lb_signed();
        mem_obs_t o;
        drive_accept(32'h103, 1'b1, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b1, 5'd3);
        serve_mem(0, 0, 32'h80FF_0000, o);
        total_cnt++;
        if (o.sel !== 4'b1000 || o.adr !== 32'h100 || o.we !== 1'b0) begin
            $display("FAIL lb_bus: sel %b adr %h we %b expected 1000 00000100 0", o.sel, o.adr, o.we);
        end else pass_cnt++;
        total_cnt++;
        if (!o.got_valid || o.data !== 32'hFFFF_FF80 || o.rw !== 1'b1 || o.ra !== 5'd3 || o.latency != 1) begin
            $display("FAIL lb_result: valid %0d data %h rw %b ra %0d lat %0d expected 1 ffffff80 1 3 1",
                     o.got_valid, o.data, o.rw, o.ra, o.latency);
        end else pass_cnt++;
    endtask

    task automatic test_sh();
        mem_obs_t o;
        drive_accept(32'h202, 1'b1, 1'b1, 32'hABCD, 4'b0011, 1'b0, 1'b1, 5'd7);
        serve_mem(0, 1, 32'h0, o);
        total_cnt++;
        if (o.sel !== 4'b1100 || o.dat !== 32'hABCD_ABCD || o.we !== 1'b1 || o.adr !== 32'h200) begin
            $display("FAIL sh_bus: sel %b dat %h we %b adr %h expected 1100 abcdabcd 1 00000200",
                     o.sel, o.dat, o.we, o.adr);
        end else pass_cnt++;
        total_cnt++;
        if (!o.got_valid || o.rw !== 1'b0 || o.cyc_at_done !== 1'b0 || o.valid_after !== 1'b0) begin
            $display("FAIL sh_done: valid %0d rw %b cyc %b valid_after %b expected 1 0 0 0",
                     o.got_valid, o.rw, o.cyc_at_done, o.valid_after);
        end else pass_cnt++;
    endtask

    task automatic test_stall();
        mem_obs_t o;
        drive_accept(32'h300, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd9);
        serve_mem(3, 2, 32'hDEAD_BEEF, o);
        total_cnt++;
        if (o.stb_cycles != 4 || o.unstable || o.ready_seen) begin
            $display("FAIL stall_bus: stb_cycles %0d unstable %0d ready_seen %0d expected 4 0 0",
                     o.stb_cycles, o.unstable, o.ready_seen);
        end else pass_cnt++;
        total_cnt++;
        if (!o.got_valid || o.data !== 32'hDEAD_BEEF || o.latency != 6) begin
            $display("FAIL stall_result: valid %0d data %h lat %0d expected 1 deadbeef 6",
                     o.got_valid, o.data, o.latency);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit seen_valid = 0;
        drive_accept(32'h400, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd4);
        @(negedge clk_i);
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        @(negedge clk_i);
        total_cnt++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
            $display("FAIL mid_wait_ack: cyc %b stb %b expected 1 0", wb_cyc_o, wb_stb_o);
        end else pass_cnt++;
        rst_ni = 1'b0;
        @(negedge clk_i);
        total_cnt++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || output_valid_o !== 1'b0) begin
            $display("FAIL mid_reset_edge: cyc %b stb %b valid %b expected 0 0 0",
                     wb_cyc_o, wb_stb_o, output_valid_o);
        end else pass_cnt++;
        rst_ni   = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_5555;
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        if (output_valid_o) seen_valid = 1;
        @(negedge clk_i);
        if (output_valid_o) seen_valid = 1;
        total_cnt++;
        if (seen_valid || debug_state_o !== 2'd0 || input_ready_o !== 1'b1) begin
            $display("FAIL late_ack: valid_seen %0d state %0d ready %b expected 0 0 1",
                     seen_valid, debug_state_o, input_ready_o);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] exp_v;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            input_valid_i = 1'b1;
            ls_enable_i   = 1'b0;
            result_i      = r;
            reg_write_i   = 1'b1;
            reg_addr_i    = 5'(i + 10);
            exp_q.push_back(r);
            @(negedge clk_i);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (output_valid_o !== 1'b1 || reg_data_o !== exp_v || reg_addr_o !== 5'(i + 10)) begin
                $display("FAIL back_to_back[%0d]: valid %b data %h addr %0d expected 1 %h %0d",
                         i, output_valid_o, reg_data_o, reg_addr_o, exp_v, i + 10);
            end else pass_cnt++;
        end
        input_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_random();
        mem_obs_t o;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ack_dat;
        logic [31:0] exp_v;
        logic        wr;
        logic        uns;
        logic        rw;
        logic [4:0]  ra;
        int          size;
        int          ofs;
        int          st;
        int          wt;
        for (int i = 0; i < 30; i++) begin
            addr    = $urandom;
            data    = $urandom;
            ack_dat = $urandom;
            uns     = 1'($urandom_range(0, 1));
            rw      = 1'($urandom_range(0, 1));
            ra      = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                exp_q.push_back(addr);
                drive_accept(addr, 1'b0, 1'b0, data, 4'b0, uns, rw, ra);
                @(negedge clk_i);
                exp_v = exp_q.pop_front();
                total_cnt++;
                if (output_valid_o !== 1'b1 || reg_data_o !== exp_v || reg_write_o !== rw || wb_cyc_o !== 1'b0) begin
                    $display("FAIL rand_pass[%0d]: valid %b data %h rw %b cyc %b expected 1 %h %b 0",
                             i, output_valid_o, reg_data_o, reg_write_o, wb_cyc_o, exp_v, rw);
                end else pass_cnt++;
            end else begin
                case ($urandom_range(0, 2))
                    0:       size = 1;
                    1:       size = 2;
                    default: size = 4;
                endcase
                ofs  = size * $urandom_range(0, (4 / size) - 1);
                addr = {addr[31:2], 2'(ofs)};
                wr   = 1'($urandom_range(0, 1));
                st   = $urandom_range(0, 2);
                wt   = $urandom_range(0, 2);
                exp_q.push_back(model_load(ack_dat, ofs, size, uns));
                drive_accept(addr, 1'b1, wr, data, size_code(size), uns, rw, ra);
                serve_mem(st, wt, ack_dat, o);
                exp_v = exp_q.pop_front();
                total_cnt++;
                if (o.adr !== {addr[31:2], 2'b00} || o.sel !== model_sel(ofs, size) || o.we !== wr ||
                    (wr && o.dat !== model_store(data, size)) || o.unstable || o.stb_cycles != st + 1) begin
                    $display("FAIL rand_bus[%0d]: adr %h sel %b we %b dat %h stb %0d expected %h %b %b %h %0d",
                             i, o.adr, o.sel, o.we, o.dat, o.stb_cycles, {addr[31:2], 2'b00},
                             model_sel(ofs, size), wr, model_store(data, size), st + 1);
                end else pass_cnt++;
                total_cnt++;
                if (!o.got_valid || o.latency != st + wt + 1 || o.rw !== (rw & ~wr) ||
                    o.ra !== ra || (!wr && o.data !== exp_v)) begin
                    $display("FAIL rand_result[%0d]: valid %0d lat %0d rw %b ra %0d data %h expected 1 %0d %b %0d %h",
                             i, o.got_valid, o.latency, o.rw, o.ra, o.data, st + wt + 1, rw & ~wr, ra, exp_v);
                end else pass_cnt++;
            end
        end
    endtask

`ifdef LOADSTORE_ALIGN_CHECK_EN
    task automatic test_misaligned();
        drive_accept(32'h101, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd6);
        @(negedge clk_i);
        total_cnt++;
        if (output_valid_o !== 1'b1 || misaligned_o !== 1'b1 || reg_write_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            $display("FAIL misaligned: valid %b mis %b rw %b cyc %b expected 1 1 0 0",
                     output_valid_o, misaligned_o, reg_write_o, wb_cyc_o);
        end else pass_cnt++;
        @(negedge clk_i);
        total_cnt++;
        if (output_valid_o !== 1'b0 || misaligned_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            $display("FAIL misaligned_pulse: valid %b mis %b cyc %b expected 0 0 0",
                     output_valid_o, misaligned_o, wb_cyc_o);
        end else pass_cnt++;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_passthrough();
        test_lb_signed();
        test_sh();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef LOADSTORE_ALIGN_CHECK_EN
        test_misaligned();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
